// File: rtl/logic_gates.sv
// Registered two-input gate bank with change counter and optional truth-table coverage.
// Coverage registers exist only when LOGIC_GATES_COVERAGE_EN is defined.
module logic_gates #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             and_out,
  output logic             nand_out,
  output logic             or_out,
  output logic             nor_out,
  output logic             xor_out,
  output logic             xnor_out,
  output logic             not_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] chg_cnt,
  output logic [3:0]       cov_out,
  output logic             cov_all
);

  logic [1:0]       w_pair;
  logic [6:0]       w_gates;
  logic             w_count;
  logic [6:0]       r_gates;
  logic [1:0]       r_prev;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  assign w_pair  = {a, b};
  // Packed as {and, nand, or, nor, xor, xnor, not}
  assign w_gates = {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b), ~a};
  // Changes only count once a previous pair is held, and the counter sticks at all-ones
  assign w_count = r_valid && (w_pair != r_prev) && !(&r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gates <= '0;
      r_prev  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_gates <= w_gates;
      r_prev  <= w_pair;
      r_valid <= 1'b1;
      if (w_count) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign and_out   = r_gates[6];
  assign nand_out  = r_gates[5];
  assign or_out    = r_gates[4];
  assign nor_out   = r_gates[3];
  assign xor_out   = r_gates[2];
  assign xnor_out  = r_gates[1];
  assign not_out   = r_gates[0];
  assign valid_out = r_valid;
  assign chg_cnt   = r_cnt;

`ifdef LOGIC_GATES_COVERAGE_EN
  logic [3:0] w_cov_next;
  logic [3:0] r_cov;
  logic       r_cov_all;

  assign w_cov_next = r_cov | (4'b0001 << w_pair);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cov     <= '0;
      r_cov_all <= 1'b0;
    end else begin
      r_cov     <= w_cov_next;
      r_cov_all <= &w_cov_next;
    end
  end

  assign cov_out = r_cov;
  assign cov_all = r_cov_all;
`else
  assign cov_out = 4'b0000;
  assign cov_all = 1'b0;
`endif

endmodule

// File: tb/tb_logic_gates.sv
// Randomized self-checking bench for logic_gates against a behavioural model;
// a second instance with CNT_W = 2 exercises counter saturation.
module tb_logic_gates;

`ifdef LOGIC_GATES_COVERAGE_EN
  localparam bit COV_EN = 1'b1;
`else
  localparam bit COV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;

  logic and8, nand8, or8, nor8, xor8, xnor8, not8, valid8, cov_all8;
  logic [7:0] cnt8;
  logic [3:0] cov8;
  logic and2, nand2, or2, nor2, xor2, xnor2, not2, valid2, cov_all2;
  logic [1:0] cnt2;
  logic [3:0] cov2;

  logic_gates #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .and_out(and8), .nand_out(nand8), .or_out(or8), .nor_out(nor8),
    .xor_out(xor8), .xnor_out(xnor8), .not_out(not8), .valid_out(valid8),
    .chg_cnt(cnt8), .cov_out(cov8), .cov_all(cov_all8)
  );

  logic_gates #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .and_out(and2), .nand_out(nand2), .or_out(or2), .nor_out(nor2),
    .xor_out(xor2), .xnor_out(xnor2), .not_out(not2), .valid_out(valid2),
    .chg_cnt(cnt2), .cov_out(cov2), .cov_all(cov_all2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit       m_valid;
  int       m_prev;
  int       m_cnt8;
  int       m_cnt2;
  bit [3:0] m_seen;
  int       m_gates;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gate_vec(input int ia, input int ib);
    int g_and, g_or, g_xor;
    g_and = ia * ib;
    g_or  = (ia + ib > 0) ? 1 : 0;
    g_xor = (ia + ib == 1) ? 1 : 0;
    return (g_and << 6) | ((1 - g_and) << 5) | (g_or << 4) | ((1 - g_or) << 3) |
           (g_xor << 2) | ((1 - g_xor) << 1) | (1 - ia);
  endfunction

  function automatic int obs8();
    return int'({and8, nand8, or8, nor8, xor8, xnor8, not8});
  endfunction

  function automatic int obs2();
    return int'({and2, nand2, or2, nor2, xor2, xnor2, not2});
  endfunction

  task automatic step(input bit ra, input bit rb, input bit rr);
    int pair;
    @(negedge clk);
    // Glitch the inputs between edges before settling on the real values
    a = ~ra;
    b = ~rb;
    #1;
    a   = ra;
    b   = rb;
    rst = rr;
    @(posedge clk);
    pair = ra * 2 + rb;
    if (rr) begin
      m_valid = 1'b0;
      m_prev  = 0;
      m_cnt8  = 0;
      m_cnt2  = 0;
      m_seen  = '0;
      m_gates = 0;
    end else begin
      if (m_valid && pair != m_prev) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
      m_gates = gate_vec(ra, rb);
      m_prev  = pair;
      m_valid = 1'b1;
      m_seen[pair] = 1'b1;
    end
    #1;
    check_eq("gates8", obs8(), m_gates);
    check_eq("gates2", obs2(), m_gates);
    check_eq("valid8", int'(valid8), int'(m_valid));
    check_eq("valid2", int'(valid2), int'(m_valid));
    check_eq("cnt8", int'(cnt8), m_cnt8);
    check_eq("cnt2", int'(cnt2), m_cnt2);
    check_eq("cov", int'(cov8), COV_EN ? int'(m_seen) : 0);
    check_eq("cov_all", int'(cov_all8), COV_EN ? int'(&m_seen) : 0);
    $display("[TB] rst=%0b ab=%0b%0b gates=%07b valid=%0b cnt8=%0d cnt2=%0d cov=%04b",
             rr, ra, rb, obs8(), valid8, cnt8, cnt2, cov8);
  endtask

  initial begin
    int base;
    step(0, 0, 1);
    step(0, 0, 1);
    check_eq("reset_gates", obs8(), 0);
    check_eq("reset_valid", int'(valid8), 0);

    // Truth table vectors
    step(0, 0, 0); check_eq("tt_00", obs8(), 7'b0101011);
    step(0, 1, 0); check_eq("tt_01", obs8(), 7'b0110101);
    step(1, 0, 0); check_eq("tt_10", obs8(), 7'b0110100);
    step(1, 1, 0); check_eq("tt_11", obs8(), 7'b1010010);

    // Change counting after reset
    step(0, 0, 1);
    step(0, 0, 0); check_eq("first_edge_cnt", int'(cnt8), 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    check_eq("chg4", int'(cnt8), 4);
    if (COV_EN) begin
      check_eq("cov_full", int'(cov8), 15);
      check_eq("cov_all_full", int'(cov_all8), 1);
    end

    // Mid-sequence reset
    step(1, 0, 1);
    check_eq("midrst_gates", obs8(), 0);
    check_eq("midrst_valid", int'(valid8), 0);
    step(1, 1, 0);
    check_eq("post_rst_valid", int'(valid8), 1);
    check_eq("post_rst_cnt", int'(cnt8), 0);

    // Saturation of the 2-bit counter
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(bit'((i + 1) % 2), 0, 0);
    check_eq("sat3", int'(cnt2), 3);
    check_eq("cnt8_6", int'(cnt8), 6);

    // Hold 11: stable outputs, no counting
    step(1, 1, 0);
    base = int'(cnt8);
    for (int i = 0; i < 10; i++) step(1, 1, 0);
    check_eq("hold_gates", obs8(), 7'b1010010);
    check_eq("hold_cnt", int'(cnt8), base);

    // Long toggle run to saturate the 8-bit counter
    for (int i = 0; i < 270; i++) step(bit'(i % 2), 0, 0);
    check_eq("sat255", int'(cnt8), 255);

    // Random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
